// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle MIPS DIV/DIVU unit: FSM encodings
// and the divide-by-zero quotient fill.
package div_unit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Divide-by-zero forces every LO bit to this value (all ones).
    localparam logic DIV0_LO_BIT = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned iter);
        return $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational two's-complement conditional negate; used as |x| on the
// operands and as the sign fixup on quotient/remainder.
module div_sign_fix #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_val,
    input  logic              i_neg,
    output logic [DATA_W-1:0] o_val
);

    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = '0 - i_val;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU; produces {HI, LO} =
// {remainder, quotient} and stalls the pipeline while iterating.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ITER   = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     in0,
    input  logic [DATA_W-1:0]     in1,
    input  logic                  annul,
    output logic                  stall,
    output logic                  valid,
    output logic [2*DATA_W-1:0]   result
);

    localparam int unsigned CNT_W = cnt_width(ITER);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvs;
    logic              r_qneg;
    logic              r_rneg;

    logic              w_div0;
    logic              w_last;
    logic              w_ge;
    logic [DATA_W-1:0] w_dvd_abs;
    logic [DATA_W-1:0] w_dvs_abs;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_sub;
    logic [DATA_W-1:0] w_rem_nx;
    logic [DATA_W-1:0] w_quo_nx;
    logic [DATA_W-1:0] w_rem_fix;
    logic [DATA_W-1:0] w_quo_fix;

    assign w_div0 = (in1 == '0);
    assign w_last = (r_cnt == CNT_W'(ITER - 1));

    div_sign_fix #(.DATA_W(DATA_W)) u_abs_dvd (
        .i_val (in0),
        .i_neg (signed_div & in0[DATA_W-1]),
        .o_val (w_dvd_abs)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_abs_dvs (
        .i_val (in1),
        .i_neg (signed_div & in1[DATA_W-1]),
        .o_val (w_dvs_abs)
    );

    // Remainder path is one bit wider so the trial subtract sees the shifted-out MSB.
    assign w_shift  = {r_rem, r_quo[DATA_W-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dvs});
    assign w_sub    = w_shift[DATA_W-1:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_sub : w_shift[DATA_W-1:0];
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};

    div_sign_fix #(.DATA_W(DATA_W)) u_fix_rem (
        .i_val (w_rem_nx),
        .i_neg (r_rneg),
        .o_val (w_rem_fix)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_fix_quo (
        .i_val (w_quo_nx),
        .i_neg (r_qneg),
        .o_val (w_quo_fix)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            result  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !annul) begin
                        if (w_div0) begin
                            result  <= {in0, {DATA_W{DIV0_LO_BIT}}};
                            r_state <= ST_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_dvd_abs;
                            r_dvs   <= w_dvs_abs;
                            r_qneg  <= signed_div & (in0[DATA_W-1] ^ in1[DATA_W-1]);
                            r_rneg  <= signed_div & in0[DATA_W-1];
                            r_cnt   <= '0;
                            r_state <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (annul) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            result  <= {w_rem_fix, w_quo_fix};
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // annul suppresses both outputs combinationally, so a flush never sees a stall or a result.
    always_comb begin
        valid = (r_state == ST_DONE) & ~annul;
        stall = ~annul & (((r_state == ST_IDLE) & start & ~w_div0) | (r_state == ST_DIV));
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS cases, randomized operands
// against an integer-arithmetic reference, annul, async reset and held start.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        annul;
    logic        stall;
    logic        valid;
    logic [63:0] result;

    int          n_tests;
    int          n_fail;
    logic [63:0] g_last_exp;

    div_unit #(.DATA_W(32), .ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .in0        (in0),
        .in1        (in1),
        .annul      (annul),
        .stall      (stall),
        .valid      (valid),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit integer division (truncating, remainder takes dividend sign).
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint la;
        longint lb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one operation and observes it; returns what the DUT did.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [63:0] res, output int lat, output int stalls,
                          output int valids);
        res    = '0;
        lat    = 0;
        stalls = 0;
        valids = 0;
        @(negedge clk);
        start      = 1'b1;
        signed_div = s;
        in0        = a;
        in1        = b;
        #1;
        if (stall) stalls++;
        @(posedge clk);
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (valid) begin
                valids++;
                if (lat == 0) begin
                    lat = n;
                    res = result;
                end
            end
            if (n == 1) begin
                start      = 1'b0;
                in0        = $urandom;
                in1        = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        in0        = '0;
        in1        = '0;
        annul      = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_tests++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        rst = 1'b1;
        g_last_exp = '0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        bit          ts [5];
        logic [63:0] te [5];
        logic [63:0] res;
        int          lat, stalls, valids, exp_lat, exp_st;
        ta[0] = 32'd100;       tb[0] = 32'd7;         ts[0] = 0; te[0] = {32'h2, 32'hE};
        ta[1] = 32'hFFFF_FFF9; tb[1] = 32'd2;         ts[1] = 1; te[1] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        ta[2] = 32'hFFFF_FFF9; tb[2] = 32'd2;         ts[2] = 0; te[2] = {32'h1, 32'h7FFF_FFFC};
        ta[3] = 32'h8000_0000; tb[3] = 32'hFFFF_FFFF; ts[3] = 1; te[3] = {32'h0, 32'h8000_0000};
        ta[4] = 32'd5;         tb[4] = 32'd0;         ts[4] = 1; te[4] = {32'h5, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], ts[i], res, lat, stalls, valids);
            exp_lat = (tb[i] == 0) ? 1 : 33;
            exp_st  = (tb[i] == 0) ? 0 : 33;
            n_tests++;
            if (res !== te[i]) begin n_fail++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, te[i]); end
            n_tests++;
            if (lat != exp_lat) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
            n_tests++;
            if (stalls != exp_st) begin n_fail++; $display("FAIL dir%0d_stall_cycles got=%0d exp=%0d", i, stalls, exp_st); end
            n_tests++;
            if (valids != 1) begin n_fail++; $display("FAIL dir%0d_valid_pulses got=%0d exp=1", i, valids); end
            g_last_exp = te[i];
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit          s;
        logic [63:0] res, exp;
        int          lat, stalls, valids;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: a = 32'h8000_0000;
                1: b = 32'($urandom_range(1, 15));
                2: b = s ? 32'hFFFF_FFFF : 32'd1;
                3: if (i % 5 == 0) b = 32'd0;
                default: ;
            endcase
            exp = model(a, b, s);
            run_op(a, b, s, res, lat, stalls, valids);
            n_tests++;
            if (res !== exp) begin n_fail++; $display("FAIL rnd%0d_result a=%h b=%h s=%0d got=%h exp=%h", i, a, b, s, res, exp); end
            n_tests++;
            if (lat != ((b == 0) ? 1 : 33)) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, (b == 0) ? 1 : 33); end
            g_last_exp = exp;
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int          lat, stalls, valids, bad_v, bad_s;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; in0 = 32'd1000; in1 = 32'd3;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        annul = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL annul_stall_comb got=%b exp=0", stall); end
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL annul_valid got=%b exp=0", valid); end
        @(negedge clk);
        annul = 1'b0;
        bad_v = 0;
        bad_s = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid) bad_v++;
            if (stall) bad_s++;
        end
        n_tests++;
        if (bad_v != 0) begin n_fail++; $display("FAIL annul_no_valid got=%0d exp=0", bad_v); end
        n_tests++;
        if (bad_s != 0) begin n_fail++; $display("FAIL annul_idle_stall got=%0d exp=0", bad_s); end
        n_tests++;
        if (result !== g_last_exp) begin n_fail++; $display("FAIL annul_result_held got=%h exp=%h", result, g_last_exp); end
        run_op(32'd9, 32'd3, 1'b0, res, lat, stalls, valids);
        n_tests++;
        if (res !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL annul_after_result got=%h exp=%h", res, {32'd0, 32'd3}); end
        n_tests++;
        if (lat != 33) begin n_fail++; $display("FAIL annul_after_latency got=%0d exp=33", lat); end
        g_last_exp = {32'd0, 32'd3};
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int          lat, stalls, valids;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; in0 = 32'd12345; in1 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL arst_stall got=%b exp=0", stall); end
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", valid); end
        n_tests++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL arst_result got=%h exp=0", result); end
        #1 rst = 1'b1;
        run_op(32'd9, 32'd3, 1'b0, res, lat, stalls, valids);
        n_tests++;
        if (lat != 33) begin n_fail++; $display("FAIL arst_first_accept latency got=%0d exp=33", lat); end
        n_tests++;
        if (res !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL arst_after_result got=%h exp=%h", res, {32'd0, 32'd3}); end
        g_last_exp = {32'd0, 32'd3};
    endtask

    task automatic test_hold_start();
        bit          exp_v;
        int          pulses;
        logic [63:0] exp;
        exp    = model(32'd50, 32'd5, 1'b0);
        pulses = 0;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; in0 = 32'd50; in1 = 32'd5;
        @(posedge clk);
        for (int n = 1; n <= 68; n++) begin
            @(negedge clk);
            // Held start: DONE at 33, IDLE at 34, re-accepted at that edge, DONE again at 67.
            exp_v = (n == 33) || (n == 67);
            if (valid) pulses++;
            if (valid !== exp_v) begin
                n_tests++;
                n_fail++;
                $display("FAIL hold_valid cycle=%0d got=%b exp=%b", n, valid, exp_v);
            end
            if (n == 33) begin
                n_tests++;
                if (result !== exp) begin n_fail++; $display("FAIL hold_result got=%h exp=%h", result, exp); end
            end
            if (n == 34) begin
                n_tests++;
                if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_idle_stall got=%b exp=1", stall); end
            end
        end
        start = 1'b0;
        n_tests++;
        if (pulses != 2) begin n_fail++; $display("FAIL hold_pulse_count got=%0d exp=2", pulses); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        g_last_exp = '0;
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_async_reset();
        test_hold_start();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
